// File: rtl/yuv2rgb_pipe.sv
// Three-stage ready/valid Y'UV to RGB converter with BT.601/BT.709 shift-add coefficients,
// bypass mode, frame-end passthrough and a saturating clip-event counter.
module yuv2rgb_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3*DATA_W-1:0] in_data,
  input  logic [1:0]          in_mode,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3*DATA_W-1:0] out_data,
  output logic                out_last,
  output logic [CNT_W-1:0]    clip_cnt,
  input  logic                clip_clr
);
  localparam int unsigned SW = DATA_W + 10;
  localparam logic [DATA_W:0] Half = {2'b01, {(DATA_W-1){1'b0}}};
  localparam logic [1:0] ModeBt601 = 2'd1;
  localparam logic [1:0] ModeBt709 = 2'd2;
  localparam logic [1:0] ModeBypass = 2'd3;

  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic ready1, ready2, ready3;

  assign ready3   = !s3_valid_q || out_ready;
  assign ready2   = !s2_valid_q || ready3;
  assign ready1   = !s1_valid_q || ready2;
  assign in_ready = ready1;

  // S1: split components, remove chroma offset where the mode uses one
  logic [DATA_W-1:0] in_y, in_u, in_v;
  logic              offset;
  logic [DATA_W:0]   u_d, v_d;

  assign {in_y, in_u, in_v} = in_data;
  assign offset = (in_mode == ModeBt601) || (in_mode == ModeBt709);
  assign u_d = offset ? ({1'b0, in_u} - Half) : {1'b0, in_u};
  assign v_d = offset ? ({1'b0, in_v} - Half) : {1'b0, in_v};

  logic [DATA_W-1:0] s1_y_q;
  logic [DATA_W:0]   s1_u_q, s1_v_q;
  logic [1:0]        s1_mode_q;
  logic              s1_last_q;

  // S2: coefficient sums in 1/32 units, shift-add only
  logic signed [SW-1:0] ue, ve, sr_d, sg_d, sb_d;

  always_comb begin
    ue = {{(SW-DATA_W-1){s1_u_q[DATA_W]}}, s1_u_q};
    ve = {{(SW-DATA_W-1){s1_v_q[DATA_W]}}, s1_v_q};
    if (s1_mode_q == ModeBt709) begin
      sr_d = (ve <<< 5) + (ve <<< 4) + (ve <<< 1);
      sg_d = -((ue <<< 2) + (ue <<< 1)) - ((ve <<< 4) - ve);
      sb_d = (ue <<< 6) - (ue <<< 2) - ue;
    end else begin
      sr_d = (ve <<< 5) + (ve <<< 2);
      sg_d = -((ue <<< 3) + (ue <<< 2) + ue) - ((ve <<< 4) + (ve <<< 1) + ve);
      sb_d = (ue <<< 6) + (ue <<< 1);
    end
  end

  logic [DATA_W-1:0]    s2_y_q;
  logic [2*DATA_W-1:0]  s2_uv_q;
  logic signed [SW-1:0] s2_sr_q, s2_sg_q, s2_sb_q;
  logic [1:0]           s2_mode_q;
  logic                 s2_last_q;

  always_ff @(posedge clk) begin
    if (ready1 && in_valid) begin
      s1_y_q    <= in_y;
      s1_u_q    <= u_d;
      s1_v_q    <= v_d;
      s1_mode_q <= in_mode;
      s1_last_q <= in_last;
    end
    if (ready2 && s1_valid_q) begin
      s2_y_q    <= s1_y_q;
      s2_uv_q   <= {s1_u_q[DATA_W-1:0], s1_v_q[DATA_W-1:0]};
      s2_sr_q   <= sr_d;
      s2_sg_q   <= sg_d;
      s2_sb_q   <= sb_d;
      s2_mode_q <= s1_mode_q;
      s2_last_q <= s1_last_q;
    end
  end

  // Returns {clipped, value}; x is known to lie within a few bits of the output range
  function automatic logic [DATA_W:0] clamp(input logic signed [SW-1:0] x);
    if (x[SW-1]) begin
      return {1'b1, {DATA_W{1'b0}}};
    end else if (|x[SW-2:DATA_W]) begin
      return {1'b1, {DATA_W{1'b1}}};
    end
    return {1'b0, x[DATA_W-1:0]};
  endfunction

  // S3: add luma, floor via arithmetic shift, clamp
  logic signed [SW-1:0] ye, r_sum, g_sum, b_sum;
  logic [DATA_W:0]      r_c, g_c, b_c;
  logic [3*DATA_W-1:0]  s3_data_d;
  logic                 s3_clip_d;

  always_comb begin
    ye    = {{(SW-DATA_W){1'b0}}, s2_y_q};
    r_sum = ye + (s2_sr_q >>> 5);
    g_sum = ye + (s2_sg_q >>> 5);
    b_sum = ye + (s2_sb_q >>> 5);
    r_c   = clamp(r_sum);
    g_c   = clamp(g_sum);
    b_c   = clamp(b_sum);
    if (s2_mode_q == ModeBypass) begin
      s3_data_d = {s2_y_q, s2_uv_q};
      s3_clip_d = 1'b0;
    end else begin
      s3_data_d = {r_c[DATA_W-1:0], g_c[DATA_W-1:0], b_c[DATA_W-1:0]};
      s3_clip_d = r_c[DATA_W] | g_c[DATA_W] | b_c[DATA_W];
    end
  end

  logic [3*DATA_W-1:0] s3_data_q;
  logic                s3_last_q, s3_clip_q;
  logic [CNT_W-1:0]    clip_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
      s3_last_q  <= 1'b0;
      s3_clip_q  <= 1'b0;
      clip_cnt_q <= '0;
    end else begin
      if (ready1) s1_valid_q <= in_valid;
      if (ready2) s2_valid_q <= s1_valid_q;
      if (ready3) s3_valid_q <= s2_valid_q;
      if (ready3 && s2_valid_q) begin
        s3_data_q <= s3_data_d;
        s3_last_q <= s2_last_q;
        s3_clip_q <= s3_clip_d;
      end
      if (clip_clr) begin
        clip_cnt_q <= '0;
      end else if (s3_valid_q && out_ready && s3_clip_q && (clip_cnt_q != {CNT_W{1'b1}})) begin
        clip_cnt_q <= clip_cnt_q + 1'b1;
      end
    end
  end

  assign out_valid = s3_valid_q;
  assign out_data  = s3_data_q;
  assign out_last  = s3_last_q;
  assign clip_cnt  = clip_cnt_q;

endmodule

// File: tb/tb_yuv2rgb_pipe.sv
// Self-checking bench for yuv2rgb_pipe: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic reference model and expected-beat queue.
module tb_yuv2rgb_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last, clip_clr;
  logic [23:0] in_data, out_data;
  logic [1:0]  in_mode;
  logic [15:0] clip_cnt;
  logic        in_ready4, out_valid4, out_last4;
  logic [23:0] out_data4;
  logic [3:0]  clip_cnt4;

  always #5 clk = ~clk;

  yuv2rgb_pipe #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .clip_cnt(clip_cnt), .clip_clr(clip_clr)
  );

  // Narrow-counter instance for saturation
  yuv2rgb_pipe #(.DATA_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_last(out_last4), .clip_cnt(clip_cnt4), .clip_clr(clip_clr)
  );

  typedef struct {
    logic [23:0] data;
    logic        last;
    bit          clip;
  } beat_t;

  beat_t       exp_q[$];
  logic [23:0] got_q[$];
  beat_t       e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          mcnt = 0;
  int          mcnt4 = 0;
  bit          prev_stall = 0;
  logic [23:0] prev_data;
  logic        prev_last;
  bit          xfer_clip;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int fdiv32(input int x);
    return (x - (((x % 32) + 32) % 32)) / 32;
  endfunction

  function automatic beat_t model(input logic [23:0] d, input logic [1:0] m, input logic l);
    beat_t b;
    int y, u, v, rv, gu, gv, bu;
    int c[3];
    b.last = l;
    b.clip = 0;
    b.data = d;
    if (m == 2'd3) return b;
    y = int'(d[23:16]);
    u = int'(d[15:8]);
    v = int'(d[7:0]);
    if (m != 2'd0) begin
      u = u - 128;
      v = v - 128;
    end
    if (m == 2'd2) begin
      rv = 50; gu = -6; gv = -15; bu = 59;
    end else begin
      rv = 36; gu = -13; gv = -19; bu = 66;
    end
    c[0] = y + fdiv32(rv * v);
    c[1] = y + fdiv32(gu * u + gv * v);
    c[2] = y + fdiv32(bu * u);
    for (int i = 0; i < 3; i++) begin
      if (c[i] < 0) begin
        c[i] = 0;
        b.clip = 1;
      end else if (c[i] > 255) begin
        c[i] = 255;
        b.clip = 1;
      end
    end
    b.data = {8'(c[0]), 8'(c[1]), 8'(c[2])};
    return b;
  endfunction

  // Monitor: samples on the falling edge what the next rising edge will do
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mcnt = 0;
      mcnt4 = 0;
      prev_stall = 0;
    end else begin
      chk("clip_cnt", 32'(clip_cnt), 32'(mcnt));
      chk("clip_cnt_w4", 32'(clip_cnt4), 32'(mcnt4));
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      xfer_clip = 0;
      if (out_valid && out_ready) begin
        chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_last", 32'(out_last), 32'(e.last));
          xfer_clip = e.clip;
        end
        got_q.push_back(out_data);
      end
      if (clip_clr) begin
        mcnt = 0;
        mcnt4 = 0;
      end else if (xfer_clip) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt4 < 15) mcnt4++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_mode, in_last));
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  // Called at posedge+1; leaves in_valid high with the beat after it is accepted
  task automatic send(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v,
                      input logic [1:0] m, input logic l);
    int t = 0;
    bit took = 0;
    in_valid = 1'b1;
    in_data = {y, u, v};
    in_mode = m;
    in_last = l;
    while (!took && t < 200) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    chk("send_accept", 32'(took), 32'd1);
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (got_q.size() < n && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("out_count", 32'(got_q.size()), 32'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int base, accepted, cyc, gs;
    bit took;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_last = 1'b0;
    out_ready = 1'b1; clip_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_clip_cnt", 32'(clip_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 1: mode 0, exact latency
    send(8'd100, 8'd0, 8'd64, 2'd0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk); chk("lat_stage1", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_stage2", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_stage3", 32'(out_valid), 32'd1);
    chk("mode0_data", 32'(out_data), 32'hAC3E64);
    @(posedge clk); #1;
    chk("mode0_noclip", 32'(clip_cnt), 32'd0);

    // 2: mode 1
    send(8'd128, 8'd128, 8'd128, 2'd1, 1'b0);
    send(8'd200, 8'd128, 8'd255, 2'd1, 1'b0);
    in_valid = 1'b0;
    wait_out(3);
    chk("mode1_grey", 32'(got_q[1]), 32'h808080);
    chk("mode1_clip", 32'(got_q[2]), 32'hFF7CC8);
    chk("mode1_cnt", 32'(clip_cnt), 32'd1);

    // 3: mode 2 then bypass back-to-back
    send(8'd50, 8'd0, 8'd128, 2'd2, 1'b0);
    send(8'd12, 8'd34, 8'd56, 2'd3, 1'b1);
    in_valid = 1'b0;
    wait_out(5);
    chk("mode2_data", 32'(got_q[3]), 32'h324A00);
    chk("bypass_data", 32'(got_q[4]), 32'h0C2238);
    chk("mode2_cnt", 32'(clip_cnt), 32'd2);

    // 4: backpressure, 6 bypass beats
    base = got_q.size();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(i * 3), 8'(i * 3 + 1), 8'(i * 3 + 2), 2'd3, i == 2);
    in_data = {8'd9, 8'd10, 8'd11};
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 3; i < 6; i++) send(8'(i * 3), 8'(i * 3 + 1), 8'(i * 3 + 2), 2'd3, i == 5);
    in_valid = 1'b0;
    wait_out(base + 6);
    for (int i = 0; i < 6; i++) begin
      chk("bp_order", 32'(got_q[base + i]), 32'({8'(i * 3), 8'(i * 3 + 1), 8'(i * 3 + 2)}));
    end

    // Random traffic with random out_ready and occasional clip_clr
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clip_clr = ($urandom_range(0, 63) == 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data = 24'($urandom);
        in_mode = 2'($urandom_range(0, 3));
        in_last = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        accepted++;
        in_valid = 1'b0;
      end
    end
    chk("rand_accepted", 32'(accepted), 32'd1000);
    in_valid = 1'b0;
    clip_clr = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    // 6: reset with beats in flight
    send(8'd200, 8'd128, 8'd255, 2'd1, 1'b0);
    in_valid = 1'b0;
    wait_out(got_q.size() + 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'd200, 8'(i), 8'd255, 2'd1, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    gs = got_q.size();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_clip_cnt", 32'(clip_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_stale", 32'(got_q.size()), 32'(gs));

    // 5: saturation and clear priority
    send(8'd200, 8'd128, 8'd255, 2'd1, 1'b0);
    in_valid = 1'b0;
    wait_out(gs + 1);
    clip_clr = 1'b1;
    @(posedge clk); #1;
    clip_clr = 1'b0;
    chk("clr_idle", 32'(clip_cnt), 32'd0);
    base = got_q.size();
    for (int i = 0; i < 20; i++) send(8'd200, 8'd128, 8'd255, 2'd1, 1'b0);
    in_valid = 1'b0;
    wait_out(base + 20);
    chk("sat_cnt4", 32'(clip_cnt4), 32'd15);
    chk("sat_cnt16", 32'(clip_cnt), 32'd20);
    base = got_q.size();
    send(8'd50, 8'd0, 8'd128, 2'd2, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clip_clr = 1'b1;
    @(posedge clk); #1;
    clip_clr = 1'b0;
    chk("clr_xfer_seen", 32'(got_q.size()), 32'(base + 1));
    @(negedge clk);
    chk("clr_prio_cnt", 32'(clip_cnt), 32'd0);
    chk("clr_prio_cnt4", 32'(clip_cnt4), 32'd0);
    @(posedge clk); #1;
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
